// File: rtl/ioctl_rom_router.sv
// rtl/ioctl_rom_router.sv - routes the data_io download byte stream into windowed SDRAM write ports
// Strobes are buffered in a small FIFO; each head byte is written to every port whose window holds it.
module ioctl_rom_router #(
    parameter int                   NPORTS     = 2,
    parameter int                   ADDR_W     = 23,
    parameter logic [NPORTS*25-1:0] BASES      = {25'h6000, 25'h0},
    parameter logic [NPORTS*25-1:0] SIZES      = {25'h4000, 25'h6000},
    parameter logic [7:0]           ROM_INDEX  = 8'd0,
    parameter int                   FIFO_DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ioctl_downl,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_wr,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic [NPORTS-1:0]        port_req,
    input  logic [NPORTS-1:0]        port_ack,
    output logic [NPORTS*ADDR_W-1:0] port_a,
    output logic [NPORTS*2-1:0]      port_ds,
    output logic [15:0]              port_d,
    output logic                     port_we,
    output logic                     rom_loaded,
    output logic                     core_reset,
    input  logic                     ext_reset,
    output logic                     overrun,
    output logic                     unmapped
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state;
    logic [32:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              wr_last, downl_last, done_pending;
    logic [NPORTS-1:0] match, lmatch;
    logic [24:0]       head_addr;
    logic [7:0]        head_data;
    logic [ADDR_W-1:0] off_a [NPORTS];
    logic              fifo_empty, fifo_full, event_wr, push, pop;

    assign {head_addr, head_data} = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign event_wr   = ioctl_wr & ~wr_last & ioctl_downl & (ioctl_index == ROM_INDEX);
    assign push       = event_wr & ~fifo_full;
    assign pop        = (state == S_IDLE) & ~fifo_empty;
    assign port_we    = ioctl_downl | (state != S_IDLE) | ~fifo_empty;

    // 26-bit compare so a window ending at the top of the 25-bit space does not wrap
    for (genvar k = 0; k < NPORTS; k++) begin : g_win
        logic [25:0] lo, hi, a26;
        assign a26      = {1'b0, head_addr};
        assign lo       = {1'b0, BASES[25*k +: 25]};
        assign hi       = lo + {1'b0, SIZES[25*k +: 25]};
        assign match[k] = (a26 >= lo) && (a26 < hi);
        assign off_a[k] = ADDR_W'((a26 - lo) >> 1);
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wr_last      <= 1'b0;
            downl_last   <= 1'b0;
            done_pending <= 1'b0;
            lmatch       <= '0;
            port_req     <= '0;
            port_a       <= '0;
            port_ds      <= '0;
            port_d       <= '0;
            rom_loaded   <= 1'b0;
            core_reset   <= 1'b1;
            overrun      <= 1'b0;
            unmapped     <= 1'b0;
        end else begin
            wr_last    <= ioctl_wr;
            downl_last <= ioctl_downl;
            core_reset <= ext_reset | ~rom_loaded;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);

            if (done_pending && fifo_empty && state == S_IDLE) begin
                rom_loaded   <= 1'b1;
                done_pending <= 1'b0;
            end
            // restart clears status; later sticky sets in this cycle still win
            if (ioctl_downl && !downl_last) begin
                rom_loaded   <= 1'b0;
                done_pending <= 1'b0;
                overrun      <= 1'b0;
                unmapped     <= 1'b0;
            end else if (!ioctl_downl && downl_last) begin
                done_pending <= 1'b1;
            end
            if (event_wr && fifo_full) overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (|match) begin
                            lmatch   <= match;
                            port_req <= port_req ^ match;
                            port_d   <= {head_data, head_data};
                            for (int k = 0; k < NPORTS; k++) begin
                                if (match[k]) begin
                                    port_a[k*ADDR_W +: ADDR_W] <= off_a[k];
                                    port_ds[2*k +: 2]          <= {head_addr[0], ~head_addr[0]};
                                end
                            end
                            state <= S_WAIT;
                        end else begin
                            unmapped <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (((port_req ^ port_ack) & lmatch) == '0) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ioctl_rom_router.sv
// tb/tb_ioctl_rom_router.sv - randomized, model-checked bench for ioctl_rom_router
module tb_ioctl_rom_router;
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset, ioctl_downl, ioctl_wr, ext_reset;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic [1:0]  port_req;
    logic [1:0]  port_ack = '0;
    logic [45:0] port_a;
    logic [3:0]  port_ds;
    logic [15:0] port_d;
    logic        port_we, rom_loaded, core_reset, overrun, unmapped;

    logic [1:0]  req2;
    logic [1:0]  ack2 = '0;
    logic [45:0] a2;
    logic [3:0]  ds2;
    logic [15:0] d2;
    logic        we2, rom2, core2, ovr2, unm2;

    ioctl_rom_router dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds),
        .port_d(port_d), .port_we(port_we), .rom_loaded(rom_loaded), .core_reset(core_reset),
        .ext_reset(ext_reset), .overrun(overrun), .unmapped(unmapped)
    );

    ioctl_rom_router #(.BASES({25'h0, 25'h0}), .SIZES({25'h100, 25'h100})) dut2 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .port_req(req2), .port_ack(ack2), .port_a(a2), .port_ds(ds2),
        .port_d(d2), .port_we(we2), .rom_loaded(rom2), .core_reset(core2),
        .ext_reset(ext_reset), .overrun(ovr2), .unmapped(unm2)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wbase(input int k);
        return (k == 0) ? 0 : 'h6000;
    endfunction
    function automatic int wsize(input int k);
        return (k == 0) ? 'h6000 : 'h4000;
    endfunction
    function automatic bit in_win(input int k, input int addr);
        return (addr >= wbase(k)) && (addr < wbase(k) + wsize(k));
    endfunction

    // Reference: FIFO contents as a queue, one write in flight at a time
    typedef struct packed { logic [24:0] a; logic [7:0] d; } ent_t;
    ent_t      mq[$];
    bit        m_busy, m_rom, m_done, m_ovr, m_unm, m_wrl, m_dll;
    bit        m_core = 1'b1;
    bit [1:0]  m_req, m_lm;
    int        m_a[2];
    bit [1:0]  m_ds[2];
    bit [15:0] m_d;

    always @(posedge clk_sys) begin : model
        int   occ;
        bit   ev, old_rom;
        ent_t e;
        bit [1:0] mt;
        if (reset) begin
            mq.delete();
            m_busy = 0; m_lm = 0; m_req = 0; m_a = '{0, 0}; m_ds = '{2'b00, 2'b00}; m_d = 0;
            m_rom = 0; m_done = 0; m_ovr = 0; m_unm = 0; m_core = 1; m_wrl = 0; m_dll = 0;
        end else begin
            occ     = mq.size();
            old_rom = m_rom;
            ev      = ioctl_wr && !m_wrl && ioctl_downl && (ioctl_index == 8'd0);
            if (m_done && occ == 0 && !m_busy) begin
                m_rom = 1; m_done = 0;
            end
            if (ioctl_downl && !m_dll) begin
                m_rom = 0; m_done = 0; m_ovr = 0; m_unm = 0;
            end else if (!ioctl_downl && m_dll) begin
                m_done = 1;
            end
            if (m_busy) begin
                if (((m_req ^ port_ack) & m_lm) == 2'b00) m_busy = 0;
            end else if (occ != 0) begin
                e  = mq.pop_front();
                mt = 0;
                for (int k = 0; k < 2; k++) begin
                    if (in_win(k, int'(e.a))) begin
                        mt[k]    = 1;
                        m_req[k] = ~m_req[k];
                        m_a[k]   = (int'(e.a) - wbase(k)) >> 1;
                        m_ds[k]  = {e.a[0], ~e.a[0]};
                    end
                end
                if (mt != 0) begin
                    m_busy = 1; m_lm = mt; m_d = {e.d, e.d};
                end else begin
                    m_unm = 1;
                end
            end
            if (ev) begin
                if (occ >= 4) m_ovr = 1;
                else begin
                    e.a = ioctl_addr; e.d = ioctl_dout;
                    mq.push_back(e);
                end
            end
            m_core = ext_reset || !old_rom;
            m_wrl  = ioctl_wr;
            m_dll  = ioctl_downl;
        end
    end

    int cnt[2], cnt2[2], wr_done[2];
    bit ack_hold;

    always @(negedge clk_sys) begin : compare_and_ack
        if (!reset) begin
            chk("port_req", port_req, m_req);
            chk("port_a", port_a, {m_a[1][22:0], m_a[0][22:0]});
            chk("port_ds", port_ds, {m_ds[1], m_ds[0]});
            chk("port_d", port_d, m_d);
            chk("port_we", port_we, ioctl_downl || m_busy || (mq.size() != 0));
            chk("rom_loaded", rom_loaded, m_rom);
            chk("core_reset", core_reset, m_core);
            chk("overrun", overrun, m_ovr);
            chk("unmapped", unmapped, m_unm);
        end
        if (reset) begin
            port_ack = '0; ack2 = '0;
            cnt = '{0, 0}; cnt2 = '{0, 0};
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!ack_hold && port_req[k] != port_ack[k]) begin
                    if (cnt[k] == 0) cnt[k] = $urandom_range(1, 4);
                    else begin
                        cnt[k]--;
                        if (cnt[k] == 0) begin
                            port_ack[k] = ~port_ack[k];
                            wr_done[k]++;
                        end
                    end
                end
                if (req2[k] != ack2[k]) begin
                    if (cnt2[k] == 0) cnt2[k] = (k == 0) ? 2 : 5;
                    else begin
                        cnt2[k]--;
                        if (cnt2[k] == 0) ack2[k] = ~ack2[k];
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic strobe(input int addr, input int data, input int gap);
        ioctl_addr = 25'(addr);
        ioctl_dout = 8'(data);
        ioctl_wr   = 1'b1;
        cyc(1);
        ioctl_wr   = 1'b0;
        cyc(gap);
    endtask

    function automatic int bnd(input int i);
        case (i)
            0: return 'h0;
            1: return 'h5FFF;
            2: return 'h6000;
            3: return 'h9FFF;
            4: return 'h5FFE;
            default: return 'h6001;
        endcase
    endfunction

    int wb0, wb1, e0, e1, tot;
    bit seen;

    initial begin
        reset = 1; ioctl_downl = 0; ioctl_index = 0; ioctl_wr = 0;
        ioctl_addr = 0; ioctl_dout = 0; ext_reset = 0; ack_hold = 0;
        cyc(3);
        chk("rst_req", port_req, 0);
        chk("rst_a", port_a, 0);
        chk("rst_ds", port_ds, 0);
        chk("rst_d", port_d, 0);
        chk("rst_we", port_we, 0);
        chk("rst_rom", rom_loaded, 0);
        chk("rst_core", core_reset, 1);
        chk("rst_ovr", overrun, 0);
        chk("rst_unm", unmapped, 0);
        reset = 0;
        cyc(2);

        // overlapping windows on the second instance
        ioctl_downl = 1;
        cyc(1);
        ioctl_addr = 25'h10; ioctl_dout = 8'hA5; ioctl_wr = 1;
        cyc(1);
        ioctl_wr = 0; ioctl_downl = 0;
        @(posedge clk_sys); #1;
        chk("ovl_req", req2, 2'b11);
        chk("ovl_a", a2, {23'h8, 23'h8});
        chk("ovl_d", d2, 16'hA5A5);
        chk("ovl_ds", ds2, 4'b0101);
        for (int i = 0; i < 20 && (ack2 != req2); i++) begin
            @(negedge clk_sys); #1;
            if (ack2[0] == req2[0] && ack2[1] != req2[1]) chk("ovl_wait_we", we2, 1);
        end
        chk("ovl_acked", ack2, 2'b11);
        cyc(3);
        chk("ovl_idle_we", we2, 0);
        cyc(8);
        chk("first_rom", rom_loaded, 1);

        // two-port split with boundary and random addresses
        wb0 = wr_done[0]; wb1 = wr_done[1]; e0 = 0; e1 = 0;
        ioctl_downl = 1;
        cyc(2);
        for (int i = 0; i < 45; i++) begin
            int a;
            a = (i < 6) ? bnd(i) : int'($urandom_range(0, 'h9FFF));
            if (in_win(0, a)) e0++;
            if (in_win(1, a)) e1++;
            strobe(a, int'($urandom_range(0, 255)), int'($urandom_range(7, 9)));
        end
        ioctl_downl = 0;
        cyc(12);
        chk("split_cnt0", wr_done[0] - wb0, e0);
        chk("split_cnt1", wr_done[1] - wb1, e1);
        chk("split_rom", rom_loaded, 1);
        chk("split_core", core_reset, 0);
        chk("split_ovr", overrun, 0);
        ext_reset = 1;
        cyc(2);
        chk("ext_core", core_reset, 1);
        ext_reset = 0;
        cyc(2);

        // overrun with acks withheld
        wb0 = wr_done[0]; ack_hold = 1; ioctl_downl = 1;
        cyc(2);
        for (int i = 0; i < 6; i++) strobe('h100 + 2 * i, i, 2);
        chk("ovr_flag", overrun, 1);
        chk("ovr_held", wr_done[0] - wb0, 0);
        ack_hold = 0; ioctl_downl = 0;
        cyc(60);
        chk("ovr_writes", wr_done[0] - wb0, 5);
        chk("ovr_rom", rom_loaded, 1);

        // unmapped byte, then a foreign-index download
        tot = wr_done[0] + wr_done[1];
        ioctl_downl = 1;
        cyc(2);
        strobe('hF000, 'h33, 8);
        chk("unm_flag", unmapped, 1);
        chk("unm_no_write", wr_done[0] + wr_done[1] - tot, 0);
        ioctl_downl = 0;
        cyc(4);
        ioctl_index = 1; ioctl_downl = 1;
        cyc(2);
        for (int i = 0; i < 3; i++) strobe('h200 + i, i, 3);
        ioctl_downl = 0;
        cyc(8);
        chk("idx_no_write", wr_done[0] + wr_done[1] - tot, 0);
        chk("idx_rom", rom_loaded, 1);
        chk("idx_unm_clr", unmapped, 0);
        ioctl_index = 0;

        // completion waits for queued bytes
        wb1 = wr_done[1]; ack_hold = 1; ioctl_downl = 1;
        cyc(2);
        for (int i = 0; i < 4; i++) strobe('h6100 + i, 'h40 + i, 2);
        ioctl_downl = 0;
        cyc(6);
        chk("cmp_rom_held", rom_loaded, 0);
        ack_hold = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc(1);
            seen = rom_loaded;
        end
        chk("cmp_rom", seen, 1);
        chk("cmp_writes", wr_done[1] - wb1, 4);

        // asynchronous reset while waiting for an ack
        ack_hold = 1; ioctl_downl = 1;
        cyc(2);
        strobe('h21, 'h5A, 3);
        reset = 1; ioctl_downl = 0;
        #1;
        chk("ar_req", port_req, 0);
        chk("ar_a", port_a, 0);
        chk("ar_ds", port_ds, 0);
        chk("ar_d", port_d, 0);
        chk("ar_we", port_we, 0);
        chk("ar_rom", rom_loaded, 0);
        chk("ar_core", core_reset, 1);
        cyc(2);
        ack_hold = 0; reset = 0;
        cyc(4);
        chk("ar_rom_after", rom_loaded, 0);
        ioctl_downl = 1;
        cyc(2);
        strobe('h6200, 'h11, 8);
        strobe('h31, 'h22, 8);
        ioctl_downl = 0;
        cyc(15);
        chk("ar_new_rom", rom_loaded, 1);
        chk("ar_new_core", core_reset, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ioctl_rom_router.md
# ioctl_rom_router

Parametrised download router between the `data_io` ioctl byte stream and up to four SDRAM write ports using the toggle req/ack handshake. It generalises the fixed two-port, fixed-offset download logic of an MCR-1 style top level:
- per-port address windows and a selectable ioctl index;
- a byte FIFO that absorbs ioctl strobes while SDRAM ports are busy;
- ack-qualified completion;
- generation of `rom_loaded` and the core reset.

It sits in the top level, between `data_io` and `sdram`.

## Interface
Parameters:
- `NPORTS`, 2: number of SDRAM write ports, 1..4.
- `ADDR_W`, 23: SDRAM word-address width per port.
- `BASES`, {25'h6000, 25'h0}: packed `NPORTS`×25-bit byte base address per port. Port k is at `[25k+24:25k]`.
- `SIZES`, {25'h4000, 25'h6000}: packed `NPORTS`×25-bit window size in bytes per port. 0 disables the port.
- `ROM_INDEX`, 8'd0: only downloads with this `ioctl_index` are routed.
- `FIFO_DEPTH`, 4: byte FIFO depth, power of 2, 2..16.

Ports:
- `clk_sys`: in, 1. System clock.
- `reset`: in, 1. Asynchronous, active-high reset.
- `ioctl_downl`: in, 1. Download active.
- `ioctl_index`: in, 8. Download index.
- `ioctl_wr`: in, 1. Byte strobe; the rising edge is the event.
- `ioctl_addr`: in, 25. Byte address.
- `ioctl_dout`: in, 8. Byte data.
- `port_req`: out, `NPORTS`. Per-port request toggle.
- `port_ack`: in, `NPORTS`. Per-port ack toggle from `sdram`.
- `port_a`: out, `NPORTS`×`ADDR_W`. Per-port word address.
- `port_ds`: out, `NPORTS`×2. Per-port byte strobes {hi, lo}.
- `port_d`: out, 16. Shared write data {byte, byte}.
- `port_we`: out, 1. High while routing is active.
- `rom_loaded`: out, 1. Set when a download completes and is fully acknowledged.
- `core_reset`: out, 1. Registered `ext_reset | ~rom_loaded`.
- `ext_reset`: in, 1. OSD/button reset request.
- `overrun`: out, 1. Sticky: a byte was dropped because the FIFO was full.
- `unmapped`: out, 1. Sticky: a byte matched no window.

## Operation
- Edge detection: register `wr_last`. An event is an edge where `ioctl_wr & ~wr_last & ioctl_downl & (ioctl_index == ROM_INDEX)`.
- On an event, `{ioctl_addr, ioctl_dout}` is pushed into the FIFO.
- If the FIFO is full on an event:
  - the byte is dropped and `overrun` is set;
  - the FIFO is unchanged.
- Match vector: port k matches when `BASES_k <= addr < BASES_k + SIZES_k`, using 26-bit arithmetic with no wrap. Windows may overlap; every matching port is written.
- Per-port output for a matching port:
  - `port_a_k = (addr - BASES_k) >> 1`, truncated to `ADDR_W`;
  - `port_ds_k = {addr[0], ~addr[0]}`;
  - `port_d = {dout, dout}`.
  - Non-matching ports keep their previous `port_a`/`port_ds`.
- FSM:
  - **IDLE**, FIFO non-empty, match ≠ 0: latch head, toggle `port_req` for all matched ports, pop, go to WAIT.
  - **IDLE**, FIFO non-empty, match = 0: pop, set `unmapped`, stay in IDLE. No toggle.
  - **WAIT**: when `port_req[k] == port_ack[k]` for every port in the latched match, go to IDLE.
- `port_we = ioctl_downl | (state != IDLE) | ~fifo_empty`.
- Completion:
  - Set `done_pending` on the falling edge of `ioctl_downl` (registered compare).
  - `rom_loaded` is set on the first edge where `done_pending & fifo_empty & IDLE`; `done_pending` clears at the same time.
- Restart: the rising edge of `ioctl_downl` clears `rom_loaded`, `done_pending`, `overrun` and `unmapped`. The FIFO is not flushed.
- A download with a non-matching index still toggles `rom_loaded` tracking, but routes nothing.

## Timing
- Reset values:
  - `port_req` = 0, `port_a` = 0, `port_ds` = 0, `port_d` = 0;
  - `port_we` = 0, `rom_loaded` = 0, `core_reset` = 1, `overrun` = 0, `unmapped` = 0;
  - FSM in IDLE, FIFO empty, `wr_last` = 0.
- Latency:
  - Event at edge E (FIFO written).
  - IDLE issues at E+1: `port_req` toggles and outputs are valid from E+1.
  - One bubble cycle in IDLE after each WAIT exit.
- An event on the same edge as a pop both takes effect, with correct occupancy. A full FIFO with a simultaneous pop still drops the byte.
- Outputs are stable from the req toggle until the matching ack returns.
- `core_reset` follows `rom_loaded`/`ext_reset` with 1 cycle of latency.
- Reset mid-download aborts immediately:
  - FIFO is cleared, `req` returns to 0;
  - the `sdram` port acks must be reset by the same reset.
  - The download is not resumed, and `rom_loaded` stays 0 until a complete new download.

## Test plan
- **Two-port split.** Default params; stream bytes at addr 0x0000..0x9FFF, one strobe per 8 clks, ack 3 clks after req.
  - Bytes < 0x6000 go to port 0 with `port_a = addr>>1`.
  - 0x6000..0x9FFF go to port 1 with `port_a = (addr-0x6000)>>1`.
  - `port_ds` = 01/10 alternating.
  - `rom_loaded` = 1 after the last ack; `core_reset` drops 1 clk later.
- **Overlap.** `BASES` = {0,0}, `SIZES` = {0x100,0x100}; write addr 0x10, data 0xA5.
  - Both `port_req` toggle at E+1.
  - Both `port_a` = 0x08, `port_d` = 0xA5A5.
  - WAIT holds until the slower ack.
- **Overrun.** `FIFO_DEPTH` = 4, ack withheld; 6 strobes.
  - 1 issued, 4 buffered, 6th dropped, `overrun` = 1.
  - Release ack: exactly 5 writes complete.
- **Unmapped/index.** Byte at 0xF000 → no toggle, `unmapped` = 1. Download with index 1 → no req toggles.
- **Completion ordering.** `ioctl_downl` falls while 3 bytes are queued.
  - `rom_loaded` stays 0 until the 3rd ack, then rises.
- **Async reset mid-transfer.** Assert `reset` in WAIT.
  - All outputs go to their reset values immediately: `core_reset` = 1, `port_req` = 0.
  - After release and a full new download, `rom_loaded` = 1.
